// File: rtl/bsg_comm_link_mux_pkg.sv
// Shared definitions for the comm link client mux: flit field positions and FSM states.
package bsg_comm_link_mux_pkg;

  // Arbitration state: free to pick a new client, or held by one client mid-packet.
  typedef enum logic {eIdle, eLocked} mux_state_e;

  // Flit layout is {last, client_id, payload}, payload in the low bits.
  function automatic int unsigned flit_last_idx(int unsigned data_width, int unsigned tag_width);
    return data_width + tag_width;
  endfunction

  function automatic int unsigned flit_tag_lsb(int unsigned data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/bsg_comm_link_client_arb.sv
// Combinational round-robin select: first requester at or above the pointer, with wrap-around.
module bsg_comm_link_client_arb #(
  parameter int unsigned num_clients_p = 4,
  localparam int unsigned tag_width_p = $clog2(num_clients_p)
) (
  input  logic [num_clients_p-1:0] req,
  input  logic [tag_width_p-1:0]   ptr,
  output logic                     grant_v,
  output logic [num_clients_p-1:0] grant_oh,
  output logic [tag_width_p-1:0]   grant_idx
);

  // Scan upward from ptr; the first hit wins and later hits are ignored.
  always_comb begin
    logic [tag_width_p-1:0] idx;
    grant_v   = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned i = 0; i < num_clients_p; i++) begin
      idx = tag_width_p'((int'(ptr) + int'(i)) % int'(num_clients_p));
      if (!grant_v && req[idx]) begin
        grant_v        = 1'b1;
        grant_oh[idx]  = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_comm_link_client_mux.sv
// Merges several client packet streams into one tagged flit stream for the comm link core.
// Round-robin arbitration happens only on packet boundaries; a watchdog caps packet length.
module bsg_comm_link_client_mux
  import bsg_comm_link_mux_pkg::*;
#(
  parameter int unsigned num_clients_p      = 4,
  parameter int unsigned data_width_p       = 29,
  parameter int unsigned max_packet_beats_p = 16,
  localparam int unsigned tag_width_p       = $clog2(num_clients_p),
  localparam int unsigned width_p           = data_width_p + tag_width_p + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_clients_p-1:0] client_v_i,
  input  logic [data_width_p-1:0]  client_data_i [num_clients_p],
  input  logic [num_clients_p-1:0] client_last_i,
  output logic [num_clients_p-1:0] client_ready_o,
  output logic                     out_v_o,
  output logic [width_p-1:0]       out_data_o,
  input  logic                     out_ready_i,
  output logic                     locked_o,
  output logic [tag_width_p-1:0]   owner_o,
  output logic                     error_r_o
);

  localparam int unsigned last_idx_lp  = flit_last_idx(data_width_p, tag_width_p);
  localparam int unsigned tag_lsb_lp   = flit_tag_lsb(data_width_p);
  localparam int unsigned cnt_width_lp = $clog2(max_packet_beats_p + 1);

  mux_state_e               state_q, state_d;
  logic [tag_width_p-1:0]   owner_q, owner_d;
  logic [tag_width_p-1:0]   ptr_q, ptr_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic                     error_q, error_d;

  logic [width_p-1:0]       fifo_mem_q [2];
  logic                     fifo_wptr_q, fifo_rptr_q;
  logic [1:0]               fifo_cnt_q;
  logic                     fifo_space, fifo_deq;

  logic                     arb_v;
  logic [num_clients_p-1:0] arb_oh;
  logic [tag_width_p-1:0]   arb_idx;

  logic                     locked;
  logic [tag_width_p-1:0]   sel_idx;
  logic [num_clients_p-1:0] ready_vec;
  logic                     accept, watchdog, flit_last;
  logic [cnt_width_lp-1:0]  beat_num;
  logic [width_p-1:0]       flit;

  bsg_comm_link_client_arb #(
    .num_clients_p(num_clients_p)
  ) arb (
    .req      (client_v_i),
    .ptr      (ptr_q),
    .grant_v  (arb_v),
    .grant_oh (arb_oh),
    .grant_idx(arb_idx)
  );

  assign fifo_space = (fifo_cnt_q != 2'd2);
  assign fifo_deq   = out_v_o & out_ready_i;

  // Grant, flit assembly, lock/pointer/watchdog next-state.
  always_comb begin
    locked    = (state_q == eLocked);
    sel_idx   = locked ? owner_q : arb_idx;
    ready_vec = '0;
    if (!reset_i && fifo_space) begin
      if (locked) ready_vec[owner_q] = 1'b1;
      else        ready_vec = arb_oh;
    end
    accept    = ready_vec[sel_idx] & client_v_i[sel_idx];

    // Beat number of the current beat within its packet, counting from 1.
    beat_num  = locked ? cnt_q + 1'b1 : cnt_width_lp'(1);
    watchdog  = accept & ~client_last_i[sel_idx]
              & (beat_num == cnt_width_lp'(max_packet_beats_p));
    flit_last = client_last_i[sel_idx] | watchdog;

    flit = '0;
    flit[last_idx_lp]                = flit_last;
    flit[last_idx_lp-1:tag_lsb_lp]   = sel_idx;
    flit[tag_lsb_lp-1:0]             = client_data_i[sel_idx];

    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    error_d = error_q | watchdog;
    if (accept) begin
      owner_d = sel_idx;
      if (flit_last) begin
        state_d = eIdle;
        cnt_d   = '0;
        ptr_d   = (sel_idx == tag_width_p'(num_clients_p - 1)) ? '0 : sel_idx + 1'b1;
      end else begin
        state_d = eLocked;
        cnt_d   = beat_num;
      end
    end
  end

  assign client_ready_o = ready_vec;

  // Control state; reset drops any in-flight packet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Two-entry output FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (accept)   fifo_wptr_q <= ~fifo_wptr_q;
      if (fifo_deq) fifo_rptr_q <= ~fifo_rptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, accept} - {1'b0, fifo_deq};
    end
  end

  // FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem_q[fifo_wptr_q] <= flit;
  end

  assign out_v_o    = (fifo_cnt_q != 2'd0);
  assign out_data_o = fifo_mem_q[fifo_rptr_q];
  assign locked_o   = (state_q == eLocked);
  assign owner_o    = owner_q;
  assign error_r_o  = error_q;

endmodule
